// File: rtl/fila_pkg.sv
// fila_pkg: shared defaults and pointer-width derivation for the fila queue
package fila_pkg;

   localparam int WIDTH_DEF = 8;
   localparam int DEPTH_DEF = 8;
   localparam int LEN_W_DEF = 8;

   // Pointer width for a given depth; never below one bit so a depth-2 queue still indexes cleanly
   function automatic int ptr_w(input int depth);
      return (depth > 2) ? $clog2(depth) : 1;
   endfunction

endpackage

// File: rtl/fila_storage.sv
// fila_storage: DEPTH x WIDTH register array with one write port and one registered read port
module fila_storage
   import fila_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF,
   parameter int DEPTH = DEPTH_DEF,
   parameter int PTR_W = ptr_w(DEPTH)
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             wr_en,
   input  logic [PTR_W-1:0] wr_addr,
   input  logic [WIDTH-1:0] wr_data,
   input  logic             rd_en,
   input  logic [PTR_W-1:0] rd_addr,
   output logic [WIDTH-1:0] rd_data
);

   logic [WIDTH-1:0] mem [DEPTH];

   // Array contents are not reset; validity is tracked by the count in the parent
   always_ff @(posedge clock) begin
      if (wr_en) mem[wr_addr] <= wr_data;
   end

   // Read register holds the last word read; a same-edge write to this address is not seen until later
   always_ff @(posedge clock) begin
      if (reset) rd_data <= '0;
      else if (rd_en) rd_data <= mem[rd_addr];
   end

endmodule

// File: rtl/fila.sv
// fila: circular-buffer FIFO with count-based full/empty and registered dequeue output
module fila
   import fila_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF,
   parameter int DEPTH = DEPTH_DEF,
   parameter int LEN_W = LEN_W_DEF
) (
   input  logic             clock,
   input  logic             reset,
   input  logic [WIDTH-1:0] data_in,
   input  logic             enqueue_in,
   input  logic             dequeue_in,
   output logic [WIDTH-1:0] data_out,
   output logic [LEN_W-1:0] len_out
);

   localparam int PTR_W = ptr_w(DEPTH);

   logic [PTR_W-1:0] wr_ptr, rd_ptr, wr_ptr_nxt, rd_ptr_nxt;
   logic [LEN_W-1:0] count, count_nxt;
   logic full, empty, enq_ok, deq_ok;

   // Acceptance: a dequeue frees the slot an enqueue needs when full; empty never falls through
   always_comb begin
      full       = count == LEN_W'(DEPTH);
      empty      = count == '0;
      deq_ok     = dequeue_in && !empty;
      enq_ok     = enqueue_in && (!full || deq_ok);
      wr_ptr_nxt = (wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
      rd_ptr_nxt = (rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
      count_nxt  = (enq_ok && !deq_ok) ? count + 1'b1 :
                   (deq_ok && !enq_ok) ? count - 1'b1 : count;
   end

   // Pointer and count registers; reset overrides any concurrent request
   always_ff @(posedge clock) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (enq_ok) wr_ptr <= wr_ptr_nxt;
         if (deq_ok) rd_ptr <= rd_ptr_nxt;
         count <= count_nxt;
      end
   end

   fila_storage #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH),
      .PTR_W (PTR_W)
   ) u_storage (
      .clock   (clock),
      .reset   (reset),
      .wr_en   (enq_ok && !reset),
      .wr_addr (wr_ptr),
      .wr_data (data_in),
      .rd_en   (deq_ok),
      .rd_addr (rd_ptr),
      .rd_data (data_out)
   );

   assign len_out = count;

endmodule

// File: tb/tb_fila.sv
// tb_fila: directed self-checking bench for the fila queue
module tb_fila;

   logic       clock = 1'b0;
   logic       reset;
   logic [7:0] data_in;
   logic       enqueue_in;
   logic       dequeue_in;
   logic [7:0] data_out;
   logic [7:0] len_out;

   int n_pass = 0;
   int n_total = 0;

   fila #(.WIDTH(8), .DEPTH(8), .LEN_W(8)) dut (
      .clock      (clock),
      .reset      (reset),
      .data_in    (data_in),
      .enqueue_in (enqueue_in),
      .dequeue_in (dequeue_in),
      .data_out   (data_out),
      .len_out    (len_out)
   );

   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
   endtask

   // Drive one edge worth of requests, then sample 1 time unit after the edge
   task automatic step(input logic e, input logic dq, input logic [7:0] d);
      enqueue_in = e;
      dequeue_in = dq;
      data_in    = d;
      @(posedge clock);
      #1;
      enqueue_in = 1'b0;
      dequeue_in = 1'b0;
   endtask

   initial begin
      reset = 1'b1;
      enqueue_in = 1'b1;
      dequeue_in = 1'b1;
      data_in = 8'hAA;
      repeat (2) @(posedge clock);
      #1;
      reset = 1'b0;
      enqueue_in = 1'b0;
      dequeue_in = 1'b0;
      check("rst_len", len_out, 0);
      check("rst_data", data_out, 0);

      for (int i = 1; i <= 8; i++) begin
         step(1, 0, 8'(i));
         check("fill_len", len_out, i);
         step(0, 0, 0);
      end
      check("full_len", len_out, 8);

      step(1, 0, 8'd9);
      check("drop_len", len_out, 8);
      check("drop_data", data_out, 0);

      for (int i = 1; i <= 8; i++) begin
         step(0, 1, 0);
         check("drain_data", data_out, i);
         check("drain_len", len_out, 8 - i);
         step(0, 0, 0);
         check("hold_data", data_out, i);
      end

      step(0, 1, 0);
      check("empty_deq_data", data_out, 8);
      check("empty_deq_len", len_out, 0);
      step(1, 1, 8'd5);
      check("empty_both_len", len_out, 1);
      check("empty_both_data", data_out, 8);
      step(0, 1, 0);
      check("empty_both_out", data_out, 5);
      check("empty_both_len2", len_out, 0);

      for (int i = 1; i <= 8; i++) step(1, 0, 8'(i));
      check("refill_len", len_out, 8);
      step(1, 1, 8'd20);
      check("full_both_data", data_out, 1);
      check("full_both_len", len_out, 8);
      for (int i = 2; i <= 9; i++) begin
         step(0, 1, 0);
         check("full_both_order", data_out, (i == 9) ? 20 : i);
      end
      check("full_both_empty", len_out, 0);

      for (int k = 1; k <= 12; k++) begin
         step(1, k >= 4, 8'(k));
         check("wrap_len", len_out, (k < 4) ? k : 3);
         check("wrap_data", data_out, (k < 4) ? 20 : k - 3);
      end
      for (int k = 10; k <= 12; k++) begin
         step(0, 1, 0);
         check("wrap_tail", data_out, k);
      end
      check("wrap_empty", len_out, 0);

      step(1, 0, 8'd33);
      step(1, 0, 8'd34);
      reset = 1'b1;
      step(1, 1, 8'd35);
      reset = 1'b0;
      check("midrst_len", len_out, 0);
      check("midrst_data", data_out, 0);
      step(1, 0, 8'd7);
      check("resume_len", len_out, 1);
      step(0, 1, 0);
      check("resume_data", data_out, 7);
      check("resume_len2", len_out, 0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
